// File: rtl/la_operand_bridge.sv
// Logic-analyzer command bridge: loads operands chunk-wise, starts the core, returns results chunk-wise.
// Commands act one edge after being presented; la_data_out is a register, no backpressure (host polls status).
module la_operand_bridge #(
  parameter int OP_W    = 163,
  parameter int N_IN    = 7,
  parameter int N_OUT   = 2,
  parameter int CHUNK_W = 82,
  parameter int TIMEOUT = 65535
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [127:0]            la_data_in,
  input  logic [127:0]            la_oenb,
  output logic [127:0]            la_data_out,
  output logic [N_IN*OP_W-1:0]    core_ops,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [N_OUT*OP_W-1:0]   core_res
);

  localparam int NCH   = (OP_W + CHUNK_W - 1) / CHUNK_W;
  localparam int NTOT  = N_IN * NCH;
  localparam int RTOT  = N_OUT * NCH;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_BUSY = 2'b11,
    S_READ = 2'b10
  } state_t;

  state_t                  state_q;
  logic [15:0]             cmd_q;
  logic [N_IN*OP_W-1:0]    ops_q;
  logic [N_OUT*OP_W-1:0]   res_q;
  logic [NTOT-1:0]         mask_q;
  logic                    all_q;
  logic                    err_q;
  logic [7:0]              idx_q;
  logic [81:0]             rdat_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    start_q;

  logic [15:0]             cmd_d;
  logic                    cmd_vld;
  int                      idx;
  int                      op_sel;
  int                      shift;
  logic [OP_W-1:0]         wr_val;
  logic [OP_W-1:0]         wr_msk;
  logic [NTOT-1:0]         mask_set;
  logic [OP_W-1:0]         rd_word;
  logic [CHUNK_W-1:0]      rd_chunk;
  logic                    unused_in;

  assign unused_in = ^{la_data_in, la_oenb};

  always_comb begin
    cmd_d   = la_data_in[31:16];
    cmd_vld = (cmd_d != cmd_q) && (la_oenb[31:16] == 16'h0000);
    idx     = int'(cmd_d[7:0]);
    op_sel  = idx / NCH;
    shift   = (idx % NCH) * CHUNK_W;
    // Chunks past OP_W fall off the top of the shift, which truncates the last chunk.
    wr_val  = OP_W'(la_data_in[32 +: CHUNK_W]) << shift;
    wr_msk  = OP_W'({CHUNK_W{1'b1}}) << shift;
    mask_set = '0;
    for (int k = 0; k < NTOT; k++) begin
      if (k == idx) mask_set[k] = 1'b1;
    end
    rd_word = '0;
    for (int r = 0; r < N_OUT; r++) begin
      if (r == op_sel) rd_word = res_q[r*OP_W +: OP_W];
    end
    rd_chunk = CHUNK_W'(rd_word >> shift);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      start_q <= 1'b0;
      if (cmd_vld && cmd_d == 16'hABFF) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (cmd_vld) begin
            if (cmd_d == 16'hAB30) begin
              state_q <= S_LOAD;
              ops_q   <= '0;
              mask_q  <= '0;
              all_q   <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_LOAD: if (cmd_vld) begin
            if (cmd_d[15:8] == 8'hAC && idx < NTOT) begin
              for (int o = 0; o < N_IN; o++) begin
                if (o == op_sel) ops_q[o*OP_W +: OP_W] <= (ops_q[o*OP_W +: OP_W] & ~wr_msk) | wr_val;
              end
              mask_q <= mask_q | mask_set;
              all_q  <= &(mask_q | mask_set);
              idx_q  <= cmd_d[7:0];
            end else if (cmd_d == 16'hAB41 && all_q) begin
              state_q <= S_BUSY;
              start_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_BUSY: begin
            if (cmd_vld) err_q <= 1'b1;
            // core_done is only honoured from the cycle after the start pulse.
            if (!start_q && core_done) begin
              res_q   <= core_res;
              state_q <= S_READ;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_READ: if (cmd_vld) begin
            if (cmd_d[15:8] == 8'hAD && idx < RTOT) begin
              rdat_q <= 82'(rd_chunk);
              idx_q  <= cmd_d[7:0];
            end else if (cmd_d == 16'hAB10) begin
              state_q <= S_IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign la_data_out = {state_q, err_q, all_q, idx_q, 2'b00, rdat_q, 32'h0};
  assign core_ops    = ops_q;
  assign core_start  = start_q;

endmodule

// File: tb/tb_la_operand_bridge.sv
// Directed bench for la_operand_bridge (TIMEOUT=8, other parameters default).
module tb_la_operand_bridge;

  localparam int OP_W  = 163;
  localparam int N_IN  = 7;
  localparam int N_OUT = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [127:0]          la_in = '0;
  logic [127:0]          oenb = {128{1'b1}};
  logic                  done = 1'b0;
  logic [N_OUT*OP_W-1:0] res = '0;
  logic [127:0]          la_out;
  logic [N_IN*OP_W-1:0]  ops;
  logic                  start;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  la_operand_bridge #(.TIMEOUT(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_data_in  (la_in),
    .la_oenb     (oenb),
    .la_data_out (la_out),
    .core_ops    (ops),
    .core_start  (start),
    .core_done   (done),
    .core_res    (res)
  );

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c, input logic [81:0] d);
    oenb[31:16]      = 16'h0000;
    la_in[31:16]     = c;
    la_in[113:32]    = d;
    tick();
  endtask

  task automatic park;
    oenb[31:16]  = 16'hFFFF;
    la_in[31:16] = 16'h0000;
    tick();
  endtask

  task automatic load_all;
    for (int i = 0; i < 14; i++) send({8'hAC, 8'(i)}, 82'(i + 1));
  endtask

  logic [162:0] op0_exp, op1_exp, op6_exp, r1;

  initial begin
    op0_exp = (163'(2) << 82) | 163'(1);
    op1_exp = (163'(4) << 82) | 163'(3);
    op6_exp = (163'(14) << 82) | 163'(13);
    r1      = (163'(12'h123) << 82) | 163'(8'h77);

    tick(); tick();
    check("rst_la_out", la_out, 128'h0);
    check("rst_start", start, 1'b0);
    check("rst_ops", ops, 0);
    rst = 1'b0;
    tick();

    // core_done outside BUSY is ignored; masked command field does nothing
    done = 1'b1; tick(); done = 1'b0;
    check("idle_done_ignored", la_out[127:126], 2'b00);
    oenb[31:16] = 16'h0001; la_in[31:16] = 16'hAB30; tick();
    check("oenb_gate", la_out[127:124], 4'b0000);
    park();

    send(16'hAB30, 82'h0);
    check("enter_load", la_out[127:125], 3'b010);
    for (int i = 0; i < 13; i++) send({8'hAC, 8'(i)}, 82'(i + 1));
    check("13_not_all", la_out[124], 1'b0);
    check("13_last_idx", la_out[123:116], 8'h0C);
    send(16'hAB41, 82'h0);
    check("early_go_err", la_out[125], 1'b1);
    check("early_go_state", la_out[127:126], 2'b01);
    check("early_go_start", start, 1'b0);
    send(16'hABFF, 82'h0);
    check("abort_keeps_err", la_out[127:125], 3'b001);

    send(16'hAB30, 82'h0);
    check("ab30_clears", la_out[125:124], 2'b00);
    send(16'hAC0E, 82'h5);
    check("oob_err", la_out[125], 1'b1);
    check("oob_mask", la_out[124], 1'b0);
    check("oob_idx", la_out[123:116], 8'h0C);
    check("oob_op0", ops[0 +: OP_W], 0);
    send(16'hABFF, 82'h0);

    send(16'hAB30, 82'h0);
    send(16'hAC00, 82'h1);
    la_in[113:32] = 82'h77;
    repeat (9) tick();
    check("hold_once", ops[0 +: OP_W], 163'h1);
    for (int i = 1; i < 14; i++) send({8'hAC, 8'(i)}, 82'(i + 1));
    check("all_loaded", la_out[125:124], 2'b01);
    check("op0", ops[0 +: OP_W], op0_exp);
    check("op6", ops[6*OP_W +: OP_W], op6_exp);
    send(16'hAC01, (82'(1) << 81) | 82'h2);
    check("trunc_op0", ops[0 +: OP_W], op0_exp);
    check("trunc_op1", ops[OP_W +: OP_W], op1_exp);
    check("trunc_idx", la_out[123:116], 8'h01);

    send(16'hAB41, 82'h0);
    check("go_start", start, 1'b1);
    check("go_state", la_out[127:126], 2'b11);
    tick();
    check("start_one_cycle", start, 1'b0);
    repeat (4) tick();
    check("busy_wait", la_out[127:126], 2'b11);
    done = 1'b1;
    res  = {r1, 163'h5A};
    tick();
    done = 1'b0;
    res  = {(N_OUT*OP_W){1'b1}};
    check("enter_read", la_out[127:126], 2'b10);
    send(16'hAD00, 82'h0);
    check("rd_r0c0", la_out[113:32], 82'h5A);
    check("rd_state", la_out[127:125], 3'b100);
    send(16'hAD03, 82'h0);
    check("rd_r1c1", la_out[113:32], 82'h123);
    send(16'hAD02, 82'h0);
    check("rd_r1c0", la_out[113:32], 82'h77);
    check("ops_held", ops[0 +: OP_W], op0_exp);
    send(16'hAD04, 82'h0);
    check("rd_oob_err", la_out[125], 1'b1);
    check("rd_oob_data", la_out[113:32], 82'h77);
    send(16'hAB10, 82'h0);
    check("read_exit", la_out[127:126], 2'b00);

    send(16'hAB30, 82'h0);
    load_all();
    send(16'hAB41, 82'h0);
    repeat (7) tick();
    check("to_still_busy", la_out[127:126], 2'b11);
    tick();
    check("timeout", la_out[127:125], 3'b001);

    send(16'hAB30, 82'h0);
    load_all();
    send(16'hAB41, 82'h0);
    tick();
    send(16'hABFF, 82'h0);
    check("abort_busy", la_out[127:125], 3'b000);
    check("abort_start", start, 1'b0);

    send(16'hAB30, 82'h0);
    load_all();
    send(16'hAB41, 82'h0);
    rst  = 1'b1;
    done = 1'b1;
    res  = {r1, 163'h5A};
    tick();
    check("rst_busy_out", la_out, 128'h0);
    check("rst_busy_start", start, 1'b0);
    check("rst_busy_ops", ops, 0);
    oenb[31:16] = 16'hFFFF;
    rst = 1'b0;
    tick();
    done = 1'b0;
    check("rst_done_dropped", la_out, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
